// File: rtl/display_pkg.sv
// display_pkg: digit width, default scan geometry and index sizing shared by the display blocks
package display_pkg;
    localparam int DIGIT_W        = 4;
    localparam int NUM_DIGITS_DEF = 4;
    localparam int SCAN_DIV_DEF   = 50000;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: free-running 0..DIV-1 prescaler with a one-cycle tick on the last count
module scan_tick_gen
    import display_pkg::*;
#(
    parameter int DIV = SCAN_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int CW = $clog2(DIV);
    logic [CW-1:0] cnt_q, cnt_d;
    assign tick = en && cnt_q == CW'(DIV - 1);
    always_comb cnt_d = !en ? cnt_q : tick ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/hex_scan_driver.sv
// hex_scan_driver: time-multiplexed hex digit scanner with frame-synchronous value update and leading-zero blanking
module hex_scan_driver
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEF,
    parameter int SCAN_DIV   = SCAN_DIV_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] value,
    input  logic                          value_valid,
    output logic                          value_ready,
    input  logic                          blank_lz,
    input  logic                          enable,
    output logic [DIGIT_W-1:0]            nibble,
    output logic [NUM_DIGITS-1:0]         digit_en_n
);
    localparam int IW = idx_w(NUM_DIGITS);
    localparam int VW = DIGIT_W * NUM_DIGITS;
    logic [IW-1:0]         idx_q, idx_d;
    logic [VW-1:0]         disp_q, disp_d, pend_q, pend_d;
    logic                  pend_full_q, pend_full_d;
    logic [DIGIT_W-1:0]    nibble_q, nibble_d, dig;
    logic [NUM_DIGITS-1:0] en_n_q, en_n_d;
    logic                  tick, wrap, accept, commit, nz, dark;
    scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (enable),
        .tick (tick)
    );
    assign value_ready = !pend_full_q && !rst;
    assign accept      = value_valid && value_ready;
    assign wrap        = tick && idx_q == IW'(NUM_DIGITS - 1);
    assign commit      = pend_full_q && (wrap || !enable);
    assign nibble      = nibble_q;
    assign digit_en_n  = en_n_q;
    // Outputs are registered from next-state so they change together with the index and display.
    always_comb begin
        idx_d       = tick ? (wrap ? '0 : idx_q + 1'b1) : idx_q;
        disp_d      = commit ? pend_q : disp_q;
        pend_d      = accept ? value : pend_q;
        pend_full_d = accept || (pend_full_q && !commit);
        nz          = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++)
            if (j >= int'(idx_d) && disp_d[DIGIT_W*j +: DIGIT_W] != '0) nz = 1'b1;
        dig         = disp_d[DIGIT_W*int'(idx_d) +: DIGIT_W];
        dark        = !enable || (blank_lz && idx_d != '0 && !nz);
        nibble_d    = dark ? '0 : dig;
        en_n_d      = dark ? '1 : ~(NUM_DIGITS'(1) << idx_d);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= '0;
            disp_q      <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            nibble_q    <= '0;
            en_n_q      <= '1;
        end else begin
            idx_q       <= idx_d;
            disp_q      <= disp_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            nibble_q    <= nibble_d;
            en_n_q      <= en_n_d;
        end
    end
endmodule

// File: tb/tb_hex_scan_driver.sv
// tb_hex_scan_driver: directed checks of scanning, blanking, frame-synchronous update, enable freeze and reset
module tb_hex_scan_driver;
    logic        clk, rst, value_valid, value_ready, blank_lz, enable;
    logic [15:0] value;
    logic [3:0]  nibble, digit_en_n;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [3:0]  en_t[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    hex_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .value       (value),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .blank_lz    (blank_lz),
        .enable      (enable),
        .nibble      (nibble),
        .digit_en_n  (digit_en_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic load(input logic [15:0] v);
        @(posedge clk); #1 value = v; value_valid = 1'b1;
        @(posedge clk); #1 value_valid = 1'b0;
    endtask

    // Returns at the first negedge of the slot whose enables become t.
    task automatic wait_into(input logic [3:0] t, output bit ok);
        logic [3:0] prev;
        prev = digit_en_n;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (digit_en_n == t && prev != t) begin ok = 1'b1; break; end
            prev = digit_en_n;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; enable = 1'b1; blank_lz = 1'b0; value_valid = 1'b0; value = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (value_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_in_rst got=%b exp=0", value_ready); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (digit_en_n !== 4'b1111 || nibble !== 4'h0 || value_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_first_cycle got en_n=%b nib=%h rdy=%b exp en_n=1111 nib=0 rdy=1", digit_en_n, nibble, value_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (digit_en_n !== 4'b1110 || nibble !== 4'h0) begin
            n_err++; $display("FAIL reset_second_cycle got en_n=%b nib=%h exp en_n=1110 nib=0", digit_en_n, nibble);
        end
    endtask

    task automatic test_scan;
        logic [3:0] nib_t[4] = '{4'h4, 4'h3, 4'h2, 4'h1};
        bit ok;
        load(16'h1234);
        wait_into(4'b1110, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL scan_wrap_timeout got=no_wrap exp=wrap"); end
        for (int s = 0; s < 8; s++)
            for (int c = 0; c < 4; c++) begin
                if (s != 0 || c != 0) @(negedge clk);
                n_cmp++;
                if (nibble !== nib_t[s%4] || digit_en_n !== en_t[s%4]) begin
                    n_err++; $display("FAIL scan_1234 slot=%0d cyc=%0d got nib=%h en_n=%b exp nib=%h en_n=%b", s, c, nibble, digit_en_n, nib_t[s%4], en_t[s%4]);
                end
            end
    endtask

    task automatic test_blank;
        logic [15:0] v_t[2] = '{16'h0050, 16'h0000};
        logic [3:0]  nb_t[2][4] = '{'{4'h0, 4'h5, 4'h0, 4'h0}, '{4'h0, 4'h0, 4'h0, 4'h0}};
        logic [3:0]  eb_t[2][4] = '{'{4'b1110, 4'b1101, 4'b1111, 4'b1111}, '{4'b1110, 4'b1111, 4'b1111, 4'b1111}};
        bit ok;
        blank_lz = 1'b1;
        for (int p = 0; p < 2; p++) begin
            load(v_t[p]);
            wait_into(4'b1110, ok);
            n_cmp++;
            if (!ok) begin n_err++; $display("FAIL blank_wrap_timeout pat=%0d got=no_wrap exp=wrap", p); end
            for (int s = 0; s < 4; s++)
                for (int c = 0; c < 4; c++) begin
                    if (s != 0 || c != 0) @(negedge clk);
                    n_cmp++;
                    if (nibble !== nb_t[p][s] || digit_en_n !== eb_t[p][s]) begin
                        n_err++; $display("FAIL blank pat=%h slot=%0d got nib=%h en_n=%b exp nib=%h en_n=%b", v_t[p], s, nibble, digit_en_n, nb_t[p][s], eb_t[p][s]);
                    end
                end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [3:0] prev;
        int n;
        @(posedge clk); #1 value = 16'hAAAA; value_valid = 1'b1;
        @(posedge clk); #1 value = 16'hBBBB;
        @(negedge clk);
        n_cmp++;
        if (value_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_after_accept got=%b exp=0", value_ready); end
        for (int i = 0; i < 40; i++) begin
            if (value_ready) break;
            @(negedge clk);
        end
        n_cmp++;
        if (value_ready !== 1'b1 || digit_en_n !== 4'b1110 || nibble !== 4'hA) begin
            n_err++; $display("FAIL b2b_commit got rdy=%b en_n=%b nib=%h exp rdy=1 en_n=1110 nib=a", value_ready, digit_en_n, nibble);
        end
        @(posedge clk); #1 value_valid = 1'b0;
        n = 0;
        prev = digit_en_n;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (digit_en_n == 4'b1110 && prev != 4'b1110) break;
            prev = digit_en_n;
            n++;
            n_cmp++;
            if (nibble !== 4'hA) begin n_err++; $display("FAIL b2b_frame_a cyc=%0d got nib=%h exp nib=a", n, nibble); end
        end
        n_cmp++;
        if (n != 15) begin n_err++; $display("FAIL b2b_frame_a_len got=%0d exp=15", n); end
        for (int s = 0; s < 4; s++)
            for (int c = 0; c < 4; c++) begin
                if (s != 0 || c != 0) @(negedge clk);
                n_cmp++;
                if (nibble !== 4'hB || digit_en_n !== en_t[s]) begin
                    n_err++; $display("FAIL b2b_frame_b slot=%0d got nib=%h en_n=%b exp nib=b en_n=%b", s, nibble, digit_en_n, en_t[s]);
                end
            end
    endtask

    task automatic test_enable;
        bit ok;
        wait_into(4'b1110, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL en_wrap_timeout got=no_wrap exp=wrap"); end
        repeat (9) @(negedge clk);
        n_cmp++;
        if (digit_en_n !== 4'b1011) begin n_err++; $display("FAIL en_pre_slot got=%b exp=1011", digit_en_n); end
        @(posedge clk); #1 enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k > 0) begin
                n_cmp++;
                if (digit_en_n !== 4'b1111) begin n_err++; $display("FAIL en_dark k=%0d got=%b exp=1111", k, digit_en_n); end
            end
            @(posedge clk);
        end
        #1 enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (digit_en_n !== 4'b1111) break;
        end
        n_cmp++;
        if (digit_en_n !== 4'b1011 || nibble !== 4'hB) begin
            n_err++; $display("FAIL en_resume got en_n=%b nib=%h exp en_n=1011 nib=b", digit_en_n, nibble);
        end
        @(negedge clk);
        n_cmp++;
        if (digit_en_n !== 4'b0111) begin n_err++; $display("FAIL en_next_slot got=%b exp=0111", digit_en_n); end
    endtask

    task automatic test_reset_midframe;
        bit ok;
        wait_into(4'b1110, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL rstmid_wrap_timeout got=no_wrap exp=wrap"); end
        repeat (8) @(negedge clk);
        load(16'h5678);
        n_cmp++;
        if (value_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_pending got rdy=%b exp=0", value_ready); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (digit_en_n !== 4'b1111 || nibble !== 4'h0 || value_ready !== 1'b0) begin
            n_err++; $display("FAIL rstmid_in_reset got en_n=%b nib=%h rdy=%b exp en_n=1111 nib=0 rdy=0", digit_en_n, nibble, value_ready);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (digit_en_n !== 4'b1111 || nibble !== 4'h0 || value_ready !== 1'b1) begin
            n_err++; $display("FAIL rstmid_after got en_n=%b nib=%h rdy=%b exp en_n=1111 nib=0 rdy=1", digit_en_n, nibble, value_ready);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n_cmp++;
            if (nibble !== 4'h0) begin n_err++; $display("FAIL rstmid_discard cyc=%0d got nib=%h exp nib=0", i, nibble); end
        end
    endtask

    initial begin
        test_reset;
        test_scan;
        test_blank;
        test_back_to_back;
        test_enable;
        test_reset_midframe;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/hex_scan_driver.md
HEX_SCAN_DRIVER -- requirements
Module: hex_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed hex digits, legal range 1..8.
REQ-002 SHALL have parameter SCAN_DIV, default 50000: clk cycles per digit slot, legal minimum 2.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port value, input, 4*NUM_DIGITS: hex value to display; digit i is value[4i+3:4i], with digit 0 the rightmost.
REQ-006 SHALL have port value_valid, input, 1: value offered this cycle.
REQ-007 SHALL have port value_ready, output, 1: block can accept value this cycle.
REQ-008 SHALL have port blank_lz, input, 1: enable leading-zero blanking.
REQ-009 SHALL have port enable, input, 1: scan enable; low means all digits dark.
REQ-010 SHALL have port nibble, output, 4: code of the active digit, feeding the downstream 7-segment decoder's 4-bit input.
REQ-011 SHALL have port digit_en_n, output, NUM_DIGITS: active-low digit enables; at most one bit low at a time.

Function
REQ-012 SHALL contain a prescaler that counts 0..SCAN_DIV-1, wraps to 0, and asserts an internal tick on the SCAN_DIV-1 cycle.
REQ-013 SHALL advance the digit index 0,1,..,NUM_DIGITS-1,0 on each tick; the NUM_DIGITS-1 -> 0 step is the frame wrap.
REQ-014 SHALL drive nibble and digit_en_n from registers; both reflect the new index in the cycle after the tick (1-cycle latency).
REQ-015 SHALL accept a value on a cycle where value_valid and value_ready are both high, storing it in a pending register and setting pending_full.
REQ-016 SHALL drive value_ready = !pending_full && !rst, combinationally.
REQ-017 SHALL, at a frame wrap with pending_full set, copy pending into the display register and clear pending_full in the same cycle; the display therefore never shows a mix of two values.
REQ-018 SHALL, when a value is accepted on a frame-wrap cycle where pending_full was clear, hold it as pending until the next frame wrap.
REQ-019 SHALL, while enable is low: hold the prescaler and index, drive digit_en_n all ones, and commit any pending value on the next cycle.
REQ-020 SHALL, when blank_lz is high, blank digit i (i>=1) if digits NUM_DIGITS-1 down to i of the display register are all zero; digit 0 is never blanked.
REQ-021 SHALL, for a blanked slot, drive digit_en_n all ones and nibble = 4'h0.

Reset
REQ-022 SHALL, on rst high at a clk edge, clear the prescaler, digit index, display register, pending register and pending_full.
REQ-023 SHALL drive nibble = 4'h0 and digit_en_n = all ones during reset and in the first cycle after reset.
REQ-024 SHALL abort a frame in progress when reset occurs mid-frame; a value pending at reset is discarded.

Structure
REQ-025 SHALL take DIGIT_W = 4 and the default NUM_DIGITS and SCAN_DIV from a shared package, display_pkg, which the decoder and top level also import.
REQ-026 SHALL implement the prescaler as one sub-module, scan_tick_gen (parameter DIV; ports clk, rst, en, tick); all other logic stays in hex_scan_driver.

Verification (NUM_DIGITS=4, SCAN_DIV=4)
REQ-027 SHALL check: reset released -> digit_en_n=4'b1111 and nibble=0 for one cycle, value_ready=1 from the first post-reset cycle.
REQ-028 SHALL check: load 16'h1234, blank_lz=0 -> after the next frame wrap, slots repeat (nibble 4, en_n 1110), (3, 1101), (2, 1011), (1, 0111), each lasting 4 cycles.
REQ-029 SHALL check: load 16'h0050, blank_lz=1 -> digits 3 and 2 dark, digit 1 shows 5, digit 0 shows 0; load 16'h0000 -> only digit 0 lit, showing 0.
REQ-030 SHALL check: back-to-back valid with 16'hAAAA then 16'hBBBB -> value_ready low after the first accept until the wrap; AAAA shows for one full frame, then BBBB.
REQ-031 SHALL check: rst pulsed in the digit-2 slot with a value pending -> all-ones enables and nibble 0; the pending value is never displayed.
REQ-032 SHALL check: enable low for 10 cycles mid-frame -> digit_en_n=1111 and the index is frozen; scanning resumes from the same digit when enable returns high.
